// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the FIFO write-side arbiter.
package fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_NREQ      = 4;
    localparam int unsigned DEF_BURST_LEN = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin search: first set req bit at or after rr_ptr+1, wrapping mod NREQ.
module rr_picker
    import fifo_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic                    found,
    output logic [$clog2(NREQ)-1:0] index
);

    localparam int unsigned PW = $clog2(NREQ);

    always_comb begin : search
        int unsigned pos;
        pos   = 0;
        found = 1'b0;
        index = '0;
        // k runs 1..NREQ so the previous owner is considered last
        for (int unsigned k = 1; k <= NREQ; k++) begin
            pos = (32'(rr_ptr) + k) % NREQ;
            if (!found && req[pos]) begin
                found = 1'b1;
                index = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding the write port of a FIFO memory.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned NREQ      = DEF_NREQ,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         ack,
    input  logic                    full,
    output logic                    w_en,
    output logic [WIDTH-1:0]        data_in,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

    arb_state_t      r_state;
    logic [PW-1:0]   r_owner;
    logic [PW-1:0]   r_rr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_found;
    logic [PW-1:0]   w_pick;
    logic            w_own_req;

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .found  (w_found),
        .index  (w_pick)
    );

    assign w_own_req = req[r_owner];

    // Gated by wrst_n so the reset edge itself can never write
    always_comb begin
        ack = '0;
        if (wrst_n && (r_state == BURST)) begin
            ack[r_owner] = w_own_req & ~full;
        end
    end

    assign w_en    = |ack;
    assign data_in = req_data[r_owner*WIDTH +: WIDTH];
    assign busy    = (r_state == BURST);
    assign owner   = r_owner;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_owner  <= '0;
            r_rr_ptr <= PW'(NREQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_owner <= w_pick;
                        r_count <= '0;
                        r_state <= BURST;
                    end
                end
                BURST: begin
                    // A dropped request ends the burst even while stalled by full
                    if (!w_own_req) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= r_owner;
                    end else if (w_en) begin
                        r_count <= r_count + 1'b1;
                        if (r_count == LAST_CNT) begin
                            r_state  <= IDLE;
                            r_rr_ptr <= r_owner;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
